oled_spi_tx: RTL and testbench

OLED_SPI_TX -- requirements
Module: oled_spi_tx

---
 rtl/oled_pkg.sv | 20 ++
 rtl/oled_sclk_div.sv | 51 +++++
 rtl/oled_spi_tx.sv | 158 +++++++++++++++
 tb/tb_oled_spi_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI command/data path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package oled_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } oled_state_t;

  // Default SCLK half-period in core clock cycles.
  localparam int OLED_SCLK_DIV = 8;

  // Number of command bytes in the panel power-up sequence.
  localparam int OLED_INIT_LEN = 47;

endpackage : oled_pkg

// File: rtl/oled_sclk_div.sv
// SCLK edge strobe generator: one-cycle rise/fall strobes every CLK_DIV cycles while enabled.
// Latency: first rise strobe in the CLK_DIV-th enabled cycle; strobes are combinational from state.
// Backpressure: none; dropping en clears counter and phase in the following cycle.
module oled_sclk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int HW = $clog2(CLK_DIV + 1);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          wrap;

  // A half-period ends on the last count of the current phase.
  assign wrap     = en && (cnt_q == HW'(CLK_DIV - 1));
  assign rise_stb = wrap && !phase_q;
  assign fall_stb = wrap && phase_q;

  // Next-state: restart from a low phase whenever disabled, flip phase at every edge.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and phase registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule : oled_sclk_div

// File: rtl/oled_spi_tx.sv
// SPI mode-0 burst transmitter for an OLED controller, driving D/C for the whole burst.
// Latency: 1 load + 2*CLK_DIV*DATA_WIDTH shift cycles per word, plus one FINISH cycle per burst.
// Backpressure: none; the source must present a valid word every cycle, start is ignored while busy.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = OLED_SCLK_DIV,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dc_sel,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_last,
  output logic                  src_rd_en,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  output logic                  spi_cs_n,
  output logic                  spi_dc,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  oled_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  last_q, last_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  dc_q, dc_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  shift_en;
  logic                  rise_stb;
  logic                  fall_stb;

  assign shift_en = (state_q == ST_SHIFT);

  oled_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shift_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Next-state and next-output logic; every output is registered so pins are glitch-free.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          dc_d    = dc_sel;
          cs_n_d  = 1'b0;
          rd_en_d = 1'b1;  // high during LOAD so the source advances as the word is taken
        end
      end
      ST_LOAD: begin
        shreg_d = src_data;
        last_d  = src_last;
        mosi_d  = src_data[DATA_WIDTH-1];
        bit_d   = '0;
        sclk_d  = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rise_stb) begin
          sclk_d = 1'b1;
        end
        if (fall_stb) begin
          sclk_d  = 1'b0;
          shreg_d = shreg_q << 1;
          mosi_d  = shreg_d[DATA_WIDTH-1];
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d = '0;
            if (last_q) begin
              state_d = ST_FINISH;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Back-to-back word: chip select stays asserted through LOAD.
              state_d = ST_LOAD;
              rd_en_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      last_q  <= 1'b0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign src_rd_en = rd_en_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_dc    = dc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : oled_spi_tx

// File: tb/tb_oled_spi_tx.sv
// Self-checking bench for oled_spi_tx at CLK_DIV = 2, 1 and 8.
// Instance 0: CLK_DIV=2, instance 1: CLK_DIV=1, instance 2: CLK_DIV=8.
// A wrapping word source per instance; a monitor on the selected instance.
module tb_oled_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dc_sel = 1'b0;
  logic [2:0] start_v = 3'b000;

  logic [7:0] src_d [3];
  logic [2:0] src_l;
  logic [2:0] rd_en_o, sclk_o, mosi_o, cs_n_o, dc_o, busy_o, done_o;

  logic [7:0] mem [64];
  int len = 1;
  int ptr [3];
  int sel = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oled_spi_tx #(.CLK_DIV(2), .DATA_WIDTH(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dc_sel(dc_sel),
    .src_data(src_d[0]), .src_last(src_l[0]), .src_rd_en(rd_en_o[0]),
    .spi_sclk(sclk_o[0]), .spi_mosi(mosi_o[0]), .spi_cs_n(cs_n_o[0]),
    .spi_dc(dc_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  oled_spi_tx #(.CLK_DIV(1), .DATA_WIDTH(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dc_sel(dc_sel),
    .src_data(src_d[1]), .src_last(src_l[1]), .src_rd_en(rd_en_o[1]),
    .spi_sclk(sclk_o[1]), .spi_mosi(mosi_o[1]), .spi_cs_n(cs_n_o[1]),
    .spi_dc(dc_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  oled_spi_tx #(.CLK_DIV(8), .DATA_WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dc_sel(dc_sel),
    .src_data(src_d[2]), .src_last(src_l[2]), .src_rd_en(rd_en_o[2]),
    .spi_sclk(sclk_o[2]), .spi_mosi(mosi_o[2]), .spi_cs_n(cs_n_o[2]),
    .spi_dc(dc_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  // Word source: combinational word at the pointer, pointer advances and wraps on rd_en.
  for (genvar g = 0; g < 3; g++) begin : g_src
    assign src_d[g] = mem[ptr[g] & 63];
    assign src_l[g] = (ptr[g] == len - 1);
    always @(posedge clk) begin
      if (!rst_n) ptr[g] <= 0;
      else if (rd_en_o[g]) ptr[g] <= (ptr[g] == len - 1) ? 0 : ptr[g] + 1;
    end
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 8;
  endfunction

  // Reference: a burst of n words costs n*(1 + 2*div*8) cycles with cs_n low, done one cycle later.
  function automatic int model_lat(input int n, input int div);
    return n * (1 + 2 * div * 8) + 1;
  endfunction

  logic sclk_m, mosi_m, cs_n_m, dc_m, busy_m, done_m, rd_en_m, start_m;
  always_comb begin
    sclk_m  = sclk_o[sel];
    mosi_m  = mosi_o[sel];
    cs_n_m  = cs_n_o[sel];
    dc_m    = dc_o[sel];
    busy_m  = busy_o[sel];
    done_m  = done_o[sel];
    rd_en_m = rd_en_o[sel];
    start_m = start_v[sel];
  end

  // Monitor, sampled on the falling clock edge.
  logic bits [$];
  int cyc = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int cs_low = 0, viol = 0, bad_run = 0, hi_run = 0;
  logic sclk_prev = 1'b0, cs_prev_low = 1'b0, dc_seen = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sclk_m && !sclk_prev) bits.push_back(mosi_m);
    sclk_prev = sclk_m;
    if (rd_en_m) rd_cnt = rd_cnt + 1;
    if (done_m) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (!cs_n_m) begin
      cs_low = cs_low + 1;
      if (!cs_prev_low) dc_seen = dc_m;
    end
    cs_prev_low = !cs_n_m;
    if (sclk_m && cs_n_m) viol = viol + 1;
    if (sclk_m) hi_run = hi_run + 1;
    else if (hi_run != 0) begin
      if (hi_run != div_of(sel)) bad_run = bad_run + 1;
      hi_run = 0;
    end
    if (start_m && !busy_m) start_cyc = cyc;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Count bytes in the captured bit stream (from base) that differ from mem[0..n-1].
  function automatic int byte_errs(input int base, input int n);
    int errs = 0;
    for (int j = 0; j < n; j++) begin
      logic [7:0] w = '0;
      for (int b = 0; b < 8; b++) begin
        int idx = base + 8 * j + b;
        w = {w[6:0], (idx < bits.size()) ? bits[idx] : 1'bx};
      end
      if (w !== mem[j]) errs++;
    end
    return errs;
  endfunction

  task automatic run_burst(input int inst, input int n, input logic dc, input int exp_lat, input string tag);
    int s_bits, s_rd, s_done, s_cs, s_viol, s_bad;
    sel = inst;
    len = n;
    s_bits = bits.size(); s_rd = rd_cnt; s_done = done_cnt;
    s_cs = cs_low; s_viol = viol; s_bad = bad_run;
    @(posedge clk); #1;
    dc_sel = dc;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    for (int k = 0; k < exp_lat + 50 && done_cnt == s_done; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done"}, done_cnt - s_done, 1);
    check({tag, " latency"}, done_cyc - start_cyc, exp_lat);
    check({tag, " cs_low"}, cs_low - s_cs, exp_lat - 1);
    check({tag, " rd_en"}, rd_cnt - s_rd, n);
    check({tag, " nbits"}, bits.size() - s_bits, n * 8);
    check({tag, " byte_errs"}, byte_errs(s_bits, n), 0);
    check({tag, " dc"}, dc_seen, dc);
    check({tag, " sclk_when_cs_hi"}, viol - s_viol, 0);
    check({tag, " sclk_hi_width"}, bad_run - s_bad, 0);
    check({tag, " busy_after"}, busy_m, 0);
    check({tag, " ptr_wrapped"}, ptr[inst], 0);
  endtask

  // Start pulses at cycle 0 and at cycles s1/s2 (relative), running total cycles.
  task automatic start_seq(input int inst, input int total, input int s1, input int s2);
    @(posedge clk); #1;
    for (int k = 0; k < total; k++) begin
      start_v[inst] = (k == 0 || k == s1 || k == s2);
      @(posedge clk); #1;
    end
    start_v[inst] = 1'b0;
  endtask

  typedef struct {
    int         inst;
    int         n;
    logic       dc;
    logic [7:0] w0;
    logic [7:0] w1;
    int         exp_lat;
  } vec_t;

  localparam logic [7:0] INIT_ROM [47] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07,
    8'h2E, 8'hB0, 8'h00, 8'h10, 8'h40, 8'h81, 8'h7F, 8'hA0, 8'hC0, 8'hD5,
    8'hF0, 8'hDA, 8'h02, 8'hA8, 8'h1F, 8'hA4, 8'hAF};

  initial begin
    vec_t vecs [4];
    int s_bits, s_rd, s_done, s_cs;
    vecs[0] = '{inst: 0, n: 2, dc: 1'b0, w0: 8'hFD, w1: 8'h12, exp_lat: 67};
    vecs[1] = '{inst: 0, n: 1, dc: 1'b1, w0: 8'hA5, w1: 8'h00, exp_lat: 34};
    vecs[2] = '{inst: 1, n: 2, dc: 1'b1, w0: 8'h3C, w1: 8'hC3, exp_lat: 35};
    vecs[3] = '{inst: 1, n: 1, dc: 1'b0, w0: 8'h81, w1: 8'h00, exp_lat: 18};
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst cs_n", cs_n_m, 1);
    check("rst sclk", sclk_m, 0);
    check("rst mosi", mosi_m, 0);
    check("rst dc", dc_m, 0);
    check("rst rd_en", rd_en_m, 0);
    check("rst busy", busy_m, 0);
    check("rst done", done_m, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors.
    for (int v = 0; v < 4; v++) begin
      mem[0] = vecs[v].w0;
      mem[1] = vecs[v].w1;
      run_burst(vecs[v].inst, vecs[v].n, vecs[v].dc, vecs[v].exp_lat, $sformatf("vec%0d", v));
    end

    // Random bursts against the reference timing/bit-stream model.
    for (int r = 0; r < 12; r++) begin
      int inst = $urandom_range(0, 1);
      int n = $urandom_range(1, 4);
      logic dc = 1'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) mem[j] = 8'($urandom);
      run_burst(inst, n, dc, model_lat(n, div_of(inst)), $sformatf("rnd%0d", r));
    end

    // Full init sequence at CLK_DIV=8.
    for (int j = 0; j < 47; j++) mem[j] = INIT_ROM[j];
    run_burst(2, 47, 1'b0, model_lat(47, 8), "init");
    s_bits = bits.size() - 8;
    check("init last byte", byte_errs(s_bits, 0) + ((s_bits >= 0) ? 0 : 1), 0);
    begin
      logic [7:0] lastw = '0;
      for (int b = 0; b < 8; b++) lastw = {lastw[6:0], bits[s_bits + b]};
      check("init last 0xAF", lastw, 8'hAF);
    end

    // Start during SHIFT (cycle 10) and during FINISH (cycle 67) is ignored.
    mem[0] = 8'hFD; mem[1] = 8'h12; len = 2; sel = 0;
    dc_sel = 1'b0;
    s_bits = bits.size(); s_rd = rd_cnt; s_done = done_cnt;
    start_seq(0, 90, 10, 67);
    check("ign done", done_cnt - s_done, 1);
    check("ign latency", done_cyc - start_cyc, 67);
    check("ign rd_en", rd_cnt - s_rd, 2);
    check("ign nbits", bits.size() - s_bits, 16);
    check("ign busy_after", busy_m, 0);

    // Start in the cycle after done starts a new burst.
    s_bits = bits.size(); s_rd = rd_cnt; s_done = done_cnt;
    start_seq(0, 150, 68, -1);
    check("b2b done", done_cnt - s_done, 2);
    check("b2b latency", done_cyc - start_cyc, 67);
    check("b2b rd_en", rd_cnt - s_rd, 4);
    check("b2b byte_errs", byte_errs(s_bits, 2) + byte_errs(s_bits + 16, 2), 0);

    // Reset at bit 4 of word 2 (CLK_DIV=2).
    s_bits = bits.size();
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
    end
    check("mid busy", busy_m, 1);
    check("mid bits", bits.size() - s_bits, 12);
    s_rd = rd_cnt; s_done = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstmid cs_n", cs_n_m, 1);
    check("rstmid sclk", sclk_m, 0);
    check("rstmid busy", busy_m, 0);
    check("rstmid rd_en", rd_en_m, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_cs = cs_low;
    repeat (60) @(posedge clk);
    #1;
    check("rstmid no done", done_cnt - s_done, 0);
    check("rstmid no rd_en", rd_cnt - s_rd, 0);
    check("rstmid cs idle", cs_low - s_cs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_oled_spi_tx
